// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  // Width of a down-counter that must hold LATENCY-1.
  function automatic int cnt_width(input int latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with a registered, read-enabled output.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
  end

  // Output only moves on reads so the last load value is held across stores.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: serves one request every LATENCY+1 cycles.
// Optional access-fault reporting is enabled with the DMEM_ERR_EN macro.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; accepts and latches the request
// WAIT  | counting down wait states on the latched request
// RESP  | ready pulse (and err when enabled); returns to IDLE
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          mem_read,
  input  logic          mem_write,
  output logic [31:0]   rdata,
  output logic          ready,
  output logic          stall
`ifdef DMEM_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = cnt_width(LATENCY);

  state_t         state;
  logic [CW-1:0]  cnt;
  op_t            op_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic           rd_err_q;

  logic           req;
  op_t            op_in;
  logic           access_now;
  op_t            acc_op;
  logic [AW-1:0]  acc_addr;
  logic [31:0]    acc_wdata;
  logic           acc_fault;
  logic [31:0]    ram_rdata;
  logic           unused_addr_bits;

  assign req   = mem_read | mem_write;
  assign op_in = mem_write ? OP_WR : OP_RD;
  assign stall = req & ~ready;

  // With LATENCY=1 the access happens on the accepting edge, so IDLE feeds live inputs.
  always_comb begin
    access_now = 1'b0;
    acc_op     = op_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    if (state == IDLE) begin
      acc_op     = op_in;
      acc_addr   = addr;
      acc_wdata  = wdata;
      access_now = req && (LATENCY == 1);
    end else if (state == WAIT) begin
      access_now = (cnt == CW'(1));
    end
  end

`ifdef DMEM_ERR_EN
  assign acc_fault = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IW + 2)) != '0);
`else
  assign acc_fault = 1'b0;
`endif
  assign unused_addr_bits = ^{acc_addr[AW-1:IW+2], acc_addr[1:0]};

  dmem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
    .clock (clock),
    .reset (reset),
    .we    (access_now && acc_op == OP_WR && !acc_fault),
    .re    (access_now && acc_op == OP_RD && !acc_fault),
    .idx   (acc_addr[IW+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign rdata = rd_err_q ? ERR_DATA : ram_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_err_q <= 1'b0;
      ready    <= 1'b0;
`ifdef DMEM_ERR_EN
      err      <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
`ifdef DMEM_ERR_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= op_in;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= CW'(LATENCY - 1);
            state   <= access_now ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (access_now) state <= RESP;
        end
        default: state <= IDLE;
      endcase

      if (access_now) begin
        ready <= 1'b1;
`ifdef DMEM_ERR_EN
        err   <= acc_fault;
`endif
        if (acc_op == OP_RD) rd_err_q <= acc_fault;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; adapts to builds with DMEM_ERR_EN.
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int AW      = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [31:0]   rdata;
  logic          ready;
  logic          stall;
  logic          err_s;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .rdata     (rdata),
    .ready     (ready),
    .stall     (stall)
`ifdef DMEM_ERR_EN
    ,
    .err       (err_s)
`endif
  );
`ifndef DMEM_ERR_EN
  assign err_s = 1'b0;
`endif

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit faults(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: word memory indexed by address modulo DEPTH.
  function automatic exp_t model(input bit rd, input bit wr, input logic [31:0] a,
                                 input logic [31:0] d);
    exp_t e;
    int   i;
    i = int'((a >> 2) % DEPTH);
    e.err = faults(a);
    if (wr) begin
      if (!e.err) mem_m[i] = d;
    end else begin
      last_rd = e.err ? 32'hDEADBEEF : mem_m[i];
    end
    e.data = last_rd;
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset && ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got 1 expected 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", rdata, e.data);
        chk("resp_err", 32'(err_s), 32'(e.err));
      end
    end
  end

  // Called just after a rising edge with the DUT in IDLE; leaves the request held
  // just after the RESP edge so the next call lands back-to-back.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d);
    int k;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    sb.push_back(model(rd, wr, a, d));
    @(negedge clock);
    chk("stall_pre_accept", 32'(stall), 32'd1);
    @(posedge clock);
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (ready) begin
        k = c;
        break;
      end
      chk("stall_wait", 32'(stall), 32'd1);
    end
    chk("ready_latency", 32'(k), 32'(LATENCY));
    chk("stall_on_ready", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [31:0] a, d;
    bit          rd;
    foreach (mem_m[i]) mem_m[i] = '0;
    last_rd = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_err", 32'(err_s), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(1);

    do_req(0, 1, 32'h10, 32'h12345678);
    idle(1);
    do_req(1, 0, 32'h10, 32'h0);
    idle(2);
    chk("rdata_held", rdata, 32'h12345678);

    do_req(1, 0, 32'h0, 32'h0);
    do_req(1, 0, 32'h4, 32'h0);
    idle(1);

    do_req(1, 1, 32'h20, 32'hA5A5A5A5);
    idle(1);
    do_req(1, 0, 32'h20, 32'h0);
    idle(1);

    // Reset during WAIT of a write: the store must be lost.
    mem_write = 1'b1;
    addr      = 32'h30;
    wdata     = 32'hCAFEF00D;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_wait_ready", 32'(ready), 32'd0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    mem_write = 1'b0;
    last_rd   = '0;
    @(negedge clock);
    chk("rst_wait_ready_after", 32'(ready), 32'd0);
    chk("rst_wait_rdata", rdata, 32'd0);
    @(posedge clock);
    #1;
    do_req(1, 0, 32'h30, 32'h0);
    idle(1);

    do_req(1, 0, 32'h2, 32'h0);
    idle(1);
    do_req(0, 1, 32'h400, 32'h11112222);
    idle(1);
    do_req(1, 0, 32'h0, 32'h0);
    idle(1);

    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1)) << 2;
      d  = $urandom;
      do_req(rd, ~rd | 1'($urandom_range(0, 1) & 0), a, d);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(3);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
